// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-MODULUS up/down counter with enable, clamped load, tc and wrap.
// Optional macro CNT_SATURATE_EN: saturate at the bounds instead of wrapping (wrap tied to 0).
module mod_updown_counter #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 10,
    parameter longint unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             at_bound;

    // Bound in the selected direction, then the next count and wrap pulse.
    always_comb begin
        at_bound = up ? (cnt_q == MAX_VAL) : (cnt_q == '0);
        tc       = en & ~load & ~rst & at_bound;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        if (load) begin
            cnt_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
`ifdef CNT_SATURATE_EN
            cnt_d = at_bound ? cnt_q : (up ? cnt_q + ONE : cnt_q - ONE);
`else
            cnt_d  = at_bound ? (up ? '0 : MAX_VAL) : (up ? cnt_q + ONE : cnt_q - ONE);
            wrap_d = at_bound;
`endif
        end
    end

    // State register; reset discards any pending load or count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= RST_CNT;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed test plan plus random stimulus against an arithmetic model.
module tb_mod_updown_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] cnt;
    logic         tc;
    logic         wrap;

    int n_tests = 0;
    int n_fail  = 0;
    int m       = 0;
    int mw      = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(W), .MODULUS(M), .RST_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .cnt(cnt), .tc(tc), .wrap(wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive, check tc before the edge, advance the model, check cnt and wrap after.
    task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv);
        int old;
        bit bound;
        rst = r; en = e; up = u; load = l; load_val = W'(lv);
        #1;
        bound = u ? (m == M - 1) : (m == 0);
        check("tc", {31'b0, tc}, {31'b0, e && !l && !r && bound});
        @(posedge clk);
        old = m;
        mw  = 0;
        if (r) m = 0;
        else if (l) m = (lv >= M) ? M - 1 : lv;
        else if (e) begin
`ifdef CNT_SATURATE_EN
            m = u ? ((m + 1 > M - 1) ? M - 1 : m + 1) : ((m - 1 < 0) ? 0 : m - 1);
`else
            m  = u ? (m + 1) % M : (m + M - 1) % M;
            mw = u ? int'(m < old) : int'(m > old);
`endif
        end
        #1;
        check("cnt", {28'b0, cnt}, m);
        check("wrap", {31'b0, wrap}, mw);
    endtask

    initial begin
        step(1, 1, 1, 1, 7);
        step(1, 1, 1, 1, 7);
        check("reset_cnt", {28'b0, cnt}, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 3);
        check("load3", {28'b0, cnt}, 3);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 13);
        check("clamp", {28'b0, cnt}, 9);
        step(0, 1, 1, 0, 0);
        check("wrap_after_clamp_cnt", {28'b0, cnt}, 0);
`ifndef CNT_SATURATE_EN
        check("wrap_after_clamp", {31'b0, wrap}, 1);
`endif
        step(0, 0, 0, 1, 5);
        for (int i = 0; i < 4; i++) step(0, 1, (i % 2) == 0, 0, 0);
        check("toggle_end", {28'b0, cnt}, 5);
        step(0, 0, 0, 1, 8);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        check("reset_mid", {28'b0, cnt}, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 15)));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
